// File: rtl/pc_next_sequencer.sv
// rtl/pc_next_sequencer.sv - registered MIPS next-PC sequencer with stall, boot bubble, irq and exception entry
module pc_next_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [WIDTH-1:0] ILLOP_VECTOR = 32'h8000_0004,
    parameter logic [WIDTH-1:0] XADR_VECTOR  = 32'h8000_0008
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic [2:0]       pc_src_i,
    input  logic             branch_cond_i,
    input  logic [15:0]      imm16_i,
    input  logic [25:0]      target26_i,
    input  logic [WIDTH-1:0] jr_addr_i,
    input  logic             irq_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             pc_valid_o,
    output logic             squash_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             xp_we_o
);

    // Sequencer states: BOOT is the single fetch bubble after reset,
    // HOLD is entered on a stall and freezes everything until it clears.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Source selector encodings from the control unit.
    localparam logic [2:0] SRC_SEQ    = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_JR     = 3'd3;
    localparam logic [2:0] SRC_ILLOP  = 3'd4;
    localparam logic [2:0] SRC_XADR   = 3'd5;
    localparam logic [2:0] SRC_RSVD6  = 3'd6;
    localparam logic [2:0] SRC_RSVD7  = 3'd7;

    localparam logic [WIDTH-1:0] FOUR = {{(WIDTH-3){1'b0}}, 3'b100};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             xp_we_q, xp_we_d;
    logic             irq_pend_q, irq_pend_d;

    logic             kernel;
    logic             advance;
    logic             illegal_op;
    logic             irq_take;
    logic             xadr_take;
    logic [WIDTH-1:0] seq_sum;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_sum;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] jmp_pc;
    logic [WIDTH-1:0] jr_pc;

    // The top PC bit is the kernel/supervisor flag.
    assign kernel = pc_q[WIDTH-1];

    // Only a running, unstalled cycle is allowed to change control flow.
    assign advance = (state_q == ST_RUN) && !stall_i;

    // Reserved encodings are treated as illegal operations.
    assign illegal_op = (pc_src_i == SRC_ILLOP) ||
                        (pc_src_i == SRC_RSVD6) ||
                        (pc_src_i == SRC_RSVD7);

    // Pending interrupts are only taken from user mode and lose to an illegal op.
    assign irq_take  = advance && !illegal_op && irq_pend_q && !kernel;
    assign xadr_take = advance && !illegal_op && !irq_take && (pc_src_i == SRC_XADR);

    // Sequential and branch targets wrap within the current mode: the
    // carry into the kernel bit is dropped and the kernel bit is kept.
    assign seq_sum   = pc_q + FOUR;
    assign seq_pc    = {kernel, seq_sum[WIDTH-2:0]};
    assign br_offset = {{(WIDTH-18){imm16_i[15]}}, imm16_i, 2'b00};
    assign br_sum    = seq_pc + br_offset;
    assign br_pc     = {kernel, br_sum[WIDTH-2:0]};
    assign jmp_pc    = {pc_q[WIDTH-1:28], target26_i, 2'b00};

    // A jr from user mode cannot set the kernel bit; kernel code may drop to user.
    assign jr_pc     = {jr_addr_i[WIDTH-1] & kernel, jr_addr_i[WIDTH-2:0]};

    // Next-state selection for the PC, mode FSM, EPC capture and irq latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        xp_we_d    = 1'b0;
        irq_pend_d = irq_pend_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = stall_i ? ST_HOLD : ST_RUN;
            ST_HOLD: state_d = stall_i ? ST_HOLD : ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (advance) begin
            if (illegal_op) begin
                pc_d    = ILLOP_VECTOR;
                epc_d   = seq_pc;
                xp_we_d = 1'b1;
            end else if (irq_take) begin
                // The interrupted instruction is squashed and re-run on return.
                pc_d       = ILLOP_VECTOR;
                epc_d      = pc_q;
                xp_we_d    = 1'b1;
                irq_pend_d = 1'b0;
            end else if (xadr_take) begin
                pc_d    = XADR_VECTOR;
                epc_d   = seq_pc;
                xp_we_d = 1'b1;
            end else begin
                case (pc_src_i)
                    SRC_SEQ:    pc_d = seq_pc;
                    SRC_BRANCH: pc_d = branch_cond_i ? br_pc : seq_pc;
                    SRC_JUMP:   pc_d = jmp_pc;
                    SRC_JR:     pc_d = jr_pc;
                    default:    pc_d = seq_pc;
                endcase
            end
        end

        // A level request is latched on every edge, even while stalled or in kernel mode.
        if (irq_i) begin
            irq_pend_d = 1'b1;
        end
    end

    // State registers; reset puts the core at the boot vector in kernel mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            xp_we_q    <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            xp_we_q    <= xp_we_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = seq_pc;
    assign pc_valid_o = (state_q == ST_RUN);
    assign squash_o   = irq_take;
    assign epc_o      = epc_q;
    assign xp_we_o    = xp_we_q;

endmodule

// File: tb/tb_pc_next_sequencer.sv
// tb/tb_pc_next_sequencer.sv - directed self-checking bench for pc_next_sequencer
module tb_pc_next_sequencer;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic [2:0]  pc_src_i;
    logic        branch_cond_i;
    logic [15:0] imm16_i;
    logic [25:0] target26_i;
    logic [31:0] jr_addr_i;
    logic        irq_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        pc_valid_o;
    logic        squash_o;
    logic [31:0] epc_o;
    logic        xp_we_o;

    int checks;
    int errors;

    pc_next_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .pc_src_i      (pc_src_i),
        .branch_cond_i (branch_cond_i),
        .imm16_i       (imm16_i),
        .target26_i    (target26_i),
        .jr_addr_i     (jr_addr_i),
        .irq_i         (irq_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .pc_valid_o    (pc_valid_o),
        .squash_o      (squash_o),
        .epc_o         (epc_o),
        .xp_we_o       (xp_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        stall_i  = 1'b0;
        pc_src_i = 3'd0;
        irq_i    = 1'b0;
        reset    = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        pc_src_i  = 3'd3;
        jr_addr_i = addr;
        tick();
        pc_src_i = 3'd0;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b0;
        #2;
        checks++;
        if (pc_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h8000_0000); end
        checks++;
        if (pc_valid_o !== 1'b0 || squash_o !== 1'b0 || xp_we_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b squash=%b xp_we=%b expected 0 0 0", pc_valid_o, squash_o, xp_we_o); end
        checks++;
        if (epc_o !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected %h", epc_o, 32'h0); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pc_valid_o !== 1'b0) begin errors++; $display("FAIL boot_bubble: got valid=%b expected 0", pc_valid_o); end
        tick();
        checks++;
        if (pc_valid_o !== 1'b1 || pc_o !== 32'h8000_0000) begin errors++; $display("FAIL boot_run: got valid=%b pc=%h expected 1 80000000", pc_valid_o, pc_o); end
        tick();
        tick();
        tick();
        checks++;
        if (pc_o !== 32'h8000_000C) begin errors++; $display("FAIL seq3_pc: got %h expected %h", pc_o, 32'h8000_000C); end
        checks++;
        if (pc_plus4_o !== 32'h8000_0010) begin errors++; $display("FAIL seq3_plus4: got %h expected %h", pc_plus4_o, 32'h8000_0010); end
    endtask

    task automatic test_branch();
        goto_pc(32'h0000_0100);
        checks++;
        if (pc_o !== 32'h0000_0100) begin errors++; $display("FAIL branch_setup: got %h expected %h", pc_o, 32'h0000_0100); end
        pc_src_i      = 3'd1;
        imm16_i       = 16'hFFFF;
        branch_cond_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h0000_0100) begin errors++; $display("FAIL branch_taken: got %h expected %h", pc_o, 32'h0000_0100); end
        branch_cond_i = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'h0000_0104) begin errors++; $display("FAIL branch_not_taken: got %h expected %h", pc_o, 32'h0000_0104); end
        imm16_i       = 16'h0010;
        branch_cond_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h0000_0148) begin errors++; $display("FAIL branch_fwd: got %h expected %h", pc_o, 32'h0000_0148); end
        pc_src_i      = 3'd0;
        branch_cond_i = 1'b0;
    endtask

    task automatic test_jr_protect();
        goto_pc(32'h0000_0040);
        pc_src_i  = 3'd3;
        jr_addr_i = 32'h8000_1000;
        tick();
        checks++;
        if (pc_o !== 32'h0000_1000) begin errors++; $display("FAIL jr_user: got %h expected %h", pc_o, 32'h0000_1000); end
        goto_pc(32'h8000_0040);
        pc_src_i  = 3'd3;
        jr_addr_i = 32'h8000_1000;
        tick();
        checks++;
        if (pc_o !== 32'h8000_1000) begin errors++; $display("FAIL jr_kernel: got %h expected %h", pc_o, 32'h8000_1000); end
        pc_src_i = 3'd0;
    endtask

    task automatic test_jump();
        goto_pc(32'h1000_0040);
        pc_src_i   = 3'd2;
        target26_i = 26'h000_0123;
        tick();
        checks++;
        if (pc_o !== 32'h1000_048C) begin errors++; $display("FAIL jump_pc: got %h expected %h", pc_o, 32'h1000_048C); end
        pc_src_i = 3'd0;
    endtask

    task automatic test_irq();
        goto_pc(32'h0000_0200);
        stall_i = 1'b1;
        irq_i   = 1'b1;
        tick();
        irq_i = 1'b0;
        checks++;
        if (pc_o !== 32'h0000_0200 || pc_valid_o !== 1'b0 || squash_o !== 1'b0) begin errors++; $display("FAIL irq_hold1: got pc=%h valid=%b squash=%b expected 00000200 0 0", pc_o, pc_valid_o, squash_o); end
        tick();
        checks++;
        if (pc_o !== 32'h0000_0200 || squash_o !== 1'b0) begin errors++; $display("FAIL irq_hold2: got pc=%h squash=%b expected 00000200 0", pc_o, squash_o); end
        stall_i = 1'b0;
        tick();
        checks++;
        if (squash_o !== 1'b1 || pc_valid_o !== 1'b1 || pc_o !== 32'h0000_0200) begin errors++; $display("FAIL irq_squash: got squash=%b valid=%b pc=%h expected 1 1 00000200", squash_o, pc_valid_o, pc_o); end
        tick();
        checks++;
        if (pc_o !== 32'h8000_0004) begin errors++; $display("FAIL irq_vector: got %h expected %h", pc_o, 32'h8000_0004); end
        checks++;
        if (xp_we_o !== 1'b1 || epc_o !== 32'h0000_0200) begin errors++; $display("FAIL irq_epc: got xp_we=%b epc=%h expected 1 00000200", xp_we_o, epc_o); end
        tick();
        checks++;
        if (xp_we_o !== 1'b0 || epc_o !== 32'h0000_0200 || squash_o !== 1'b0) begin errors++; $display("FAIL irq_after: got xp_we=%b epc=%h squash=%b expected 0 00000200 0", xp_we_o, epc_o, squash_o); end
    endtask

    task automatic test_priority();
        goto_pc(32'h0000_0300);
        stall_i = 1'b1;
        irq_i   = 1'b1;
        tick();
        stall_i = 1'b0;
        irq_i   = 1'b0;
        tick();
        pc_src_i = 3'd4;
        #1;
        checks++;
        if (squash_o !== 1'b0) begin errors++; $display("FAIL prio_no_squash: got %b expected 0", squash_o); end
        tick();
        checks++;
        if (pc_o !== 32'h8000_0004 || epc_o !== 32'h0000_0304 || xp_we_o !== 1'b1) begin errors++; $display("FAIL prio_illop: got pc=%h epc=%h xp_we=%b expected 80000004 00000304 1", pc_o, epc_o, xp_we_o); end
        pc_src_i = 3'd0;
        tick();
        checks++;
        if (pc_o !== 32'h8000_0008 || squash_o !== 1'b0) begin errors++; $display("FAIL prio_kernel_wait: got pc=%h squash=%b expected 80000008 0", pc_o, squash_o); end
        pc_src_i  = 3'd3;
        jr_addr_i = 32'h0000_0500;
        tick();
        pc_src_i = 3'd0;
        #1;
        checks++;
        if (pc_o !== 32'h0000_0500 || squash_o !== 1'b1) begin errors++; $display("FAIL prio_user_irq: got pc=%h squash=%b expected 00000500 1", pc_o, squash_o); end
        tick();
        checks++;
        if (pc_o !== 32'h8000_0004 || epc_o !== 32'h0000_0500 || xp_we_o !== 1'b1) begin errors++; $display("FAIL prio_irq_taken: got pc=%h epc=%h xp_we=%b expected 80000004 00000500 1", pc_o, epc_o, xp_we_o); end
    endtask

    task automatic test_wrap_async_reset();
        goto_pc(32'h7FFF_FFFC);
        tick();
        checks++;
        if (pc_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc_o, 32'h0000_0000); end
        pc_src_i = 3'd5;
        tick();
        checks++;
        if (pc_o !== 32'h8000_0008 || epc_o !== 32'h0000_0004 || xp_we_o !== 1'b1) begin errors++; $display("FAIL xadr_entry: got pc=%h epc=%h xp_we=%b expected 80000008 00000004 1", pc_o, epc_o, xp_we_o); end
        pc_src_i = 3'd0;
        stall_i  = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h8000_0008 || pc_valid_o !== 1'b0) begin errors++; $display("FAIL hold_state: got pc=%h valid=%b expected 80000008 0", pc_o, pc_valid_o); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h8000_0000 || epc_o !== 32'h0 || pc_valid_o !== 1'b0 || xp_we_o !== 1'b0) begin errors++; $display("FAIL async_reset: got pc=%h epc=%h valid=%b xp_we=%b expected 80000000 00000000 0 0", pc_o, epc_o, pc_valid_o, xp_we_o); end
        stall_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        stall_i       = 1'b0;
        pc_src_i      = 3'd0;
        branch_cond_i = 1'b0;
        imm16_i       = 16'h0;
        target26_i    = 26'h0;
        jr_addr_i     = 32'h0;
        irq_i         = 1'b0;
        test_reset();
        test_branch();
        test_jr_protect();
        test_jump();
        test_irq();
        test_priority();
        test_wrap_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
